// File: rtl/alu_fpga_ctrl.sv
// alu_fpga_ctrl: DE2 operator console wrapped around the ALU.
// Conditions the four pushbuttons, sequences the load-A / load-B / select-op /
// run steps, registers operands and opcode, latches the ALU result and flags,
// and drives DIGITS seven-segment digits plus the status LEDs.
`timescale 1ns/1ps

module alu_fpga_ctrl #(
    parameter int DIGITS          = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    input  logic [3:0]            KEY,
    input  logic [17:0]           SW,
    output logic [3:0]            op,
    output logic [31:0]           port_a,
    output logic [31:0]           port_b,
    input  logic [31:0]           ans,
    input  logic                  nf,
    input  logic                  vf,
    input  logic                  zf,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [17:0]           LEDR,
    output logic [8:0]            LEDG
);

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_OP, S_RUN} state_t;
    typedef enum logic [1:0] {V_RES, V_A, V_B} view_t;

    // Active-low seven-segment pattern for one hex nibble, bit order g..a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'b1000000;
            4'h1:    return 7'b1111001;
            4'h2:    return 7'b0100100;
            4'h3:    return 7'b0110000;
            4'h4:    return 7'b0011001;
            4'h5:    return 7'b0010010;
            4'h6:    return 7'b0000010;
            4'h7:    return 7'b1111000;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0010000;
            4'hA:    return 7'b0001000;
            4'hB:    return 7'b0000011;
            4'hC:    return 7'b0100111;
            4'hD:    return 7'b0100001;
            4'hE:    return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // True when any nibble beyond the driven digits is nonzero.
    function automatic logic hidden_nz(input logic [31:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= DIGITS && v[4*i +: 4] != 4'h0) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Display view rotation RES -> A -> B -> RES.
    function automatic view_t view_next(input view_t v);
        case (v)
            V_RES:   return V_A;
            V_A:     return V_B;
            default: return V_RES;
        endcase
    endfunction

    logic [3:0]     key_p0;
    logic [3:0]     key_p1;
    logic [3:0]     db;
    logic [CW-1:0]  cnt [4];
    logic [3:0]     kp;

    state_t         state;
    view_t          view;
    logic [31:0]    res_q;
    logic           zf_q;
    logic           nf_q;
    logic           vf_q;

    logic [31:0]    sw_val;
    logic [31:0]    dval;

    assign sw_val = {{16{SW[16]}}, SW[15:0]};

    // Two-flop synchroniser for the asynchronous pushbuttons (idle high).
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            key_p0 <= 4'hF;
            key_p1 <= 4'hF;
        end else begin
            key_p0 <= KEY;
            key_p1 <= key_p0;
        end
    end

    // Debounce: a change must persist until the counter reaches its limit.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            db <= 4'hF;
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (key_p1[k] != db[k]) begin
                    if (cnt[k] == CNT_MAX) begin
                        db[k]  <= ~db[k];
                        cnt[k] <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + CW'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end

    // Press pulse: the cycle whose edge flips a debounced level from 1 to 0.
    always_comb begin
        kp = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            kp[k] = db[k] && !key_p1[k] && (cnt[k] == CNT_MAX);
        end
    end

    // Operator sequencer with operand/opcode registers and result capture.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            state  <= S_LOAD_A;
            view   <= V_RES;
            port_a <= 32'd0;
            port_b <= 32'd0;
            op     <= 4'd0;
            res_q  <= 32'd0;
            zf_q   <= 1'b0;
            nf_q   <= 1'b0;
            vf_q   <= 1'b0;
        end else begin
            if (state == S_RUN) begin
                res_q <= ans;
                zf_q  <= zf;
                nf_q  <= nf;
                vf_q  <= vf;
            end
            if (kp[1]) begin
                state  <= S_LOAD_A;
                port_a <= 32'd0;
                port_b <= 32'd0;
                op     <= 4'd0;
                res_q  <= 32'd0;
                zf_q   <= 1'b0;
                nf_q   <= 1'b0;
                vf_q   <= 1'b0;
            end else if (kp[0]) begin
                case (state)
                    S_LOAD_A: begin
                        port_a <= sw_val;
                        state  <= S_LOAD_B;
                    end
                    S_LOAD_B: begin
                        port_b <= sw_val;
                        state  <= S_OP;
                    end
                    S_OP: begin
                        op    <= SW[3:0];
                        view  <= V_RES;
                        state <= S_RUN;
                    end
                    default: begin
                        state <= S_LOAD_A;
                    end
                endcase
            end else if (kp[2]) begin
                if (state == S_RUN) begin
                    view <= view_next(view);
                end
            end else if (kp[3]) begin
                // Reserved key: debounced like the others but has no action.
            end
        end
    end

    // Switch mirror on the red LEDs.
    always_ff @(posedge CLOCK_50 or posedge RST) begin
        if (RST) begin
            LEDR <= 18'd0;
        end else begin
            LEDR <= SW;
        end
    end

    // Select the value shown on the seven-segment display.
    always_comb begin
        dval = sw_val;
        case (state)
            S_LOAD_A, S_LOAD_B: dval = sw_val;
            S_OP:               dval = {28'd0, SW[3:0]};
            default: begin
                case (view)
                    V_A:     dval = port_a;
                    V_B:     dval = port_b;
                    default: dval = res_q;
                endcase
            end
        endcase
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign HEX[7*i +: 7] = seg7(dval[4*i +: 4]);
    end

    assign LEDG[0] = (state == S_LOAD_A);
    assign LEDG[1] = (state == S_LOAD_B);
    assign LEDG[2] = (state == S_OP);
    assign LEDG[3] = (state == S_RUN);
    assign LEDG[4] = zf_q;
    assign LEDG[5] = nf_q;
    assign LEDG[6] = vf_q;
    assign LEDG[7] = (view != V_RES);
    assign LEDG[8] = hidden_nz(dval);

endmodule

// File: doc/alu_fpga_ctrl.md
# alu_fpga_ctrl

Board-level operator console for the ALU on the DE2 FPGA: debounces the four pushbuttons, walks the operator through load-A / load-B / select-op / run steps, and registers operands and opcode for the ALU. It latches the ALU result and flags, and drives a parametrised number of seven-segment digits with a selectable view (result, A, B). It sits between the board pins and the `alu` instance, so `alu` keeps its existing port list.

## Interface

- `DIGITS`, 8: number of hex digits driven, range 1..8; digit i shows nibble i of the displayed value.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before a key change is accepted; must be ≥1.
- `CLOCK_50`  in  1  system clock; the only clock.
- `RST`  in  1  asynchronous, active-high reset.
- `KEY`  in  4  pushbuttons, active-low, asynchronous to `CLOCK_50`.
- `SW`  in  18  slide switches, asynchronous.
- `op`  out  4  registered ALU opcode.
- `port_a`, `port_b`  out  32  registered ALU operands.
- `ans`  in  32  combinational ALU result.
- `nf`, `vf`, `zf`  in  1  combinational ALU flags.
- `HEX`  out  7*DIGITS  active-low segments; `HEX[7i+6:7i]` is digit i, bit order g..a.
- `LEDR`  out  18  registered copy of `SW`.
- `LEDG`  out  9  status LEDs.

## Operation

- **Key conditioning, per key:**
  - 2-FF synchroniser, then a debounced level register and a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - When the synced input differs from the debounced level, the counter increments. Any cycle where they agree clears the counter.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - A press pulse `kp[k]` is high for exactly one cycle on a debounced 1→0 transition. Release produces no pulse.
- **Operand source:** `sw_val` = `{ {16{SW[16]}}, SW[15:0] }`.
- **FSM states:** `S_LOAD_A`, `S_LOAD_B`, `S_OP`, `S_RUN`. Reset state is `S_LOAD_A`.
  - `kp[1]` (clear), in any state: go to `S_LOAD_A`; `port_a`, `port_b`, `op`, `res_q` and the flags all become 0. Clear has priority over every other key in the same cycle.
  - `kp[0]` (enter):
    - `S_LOAD_A`: `port_a` ← `sw_val`, go to `S_LOAD_B`.
    - `S_LOAD_B`: `port_b` ← `sw_val`, go to `S_OP`.
    - `S_OP`: `op` ← `SW[3:0]`, go to `S_RUN`.
    - `S_RUN`: go to `S_LOAD_A`; operands and `op` are kept.
  - `kp[2]` (view), only in `S_RUN`: `view` cycles RES→A→B→RES. `view` is forced to RES on every entry into `S_RUN`. Ignored in other states.
  - `kp[3]`: reserved, ignored.
- **Result capture:** while the state is `S_RUN`, `res_q` ← `ans`, `zf_q` ← `zf`, `nf_q` ← `nf`, `vf_q` ← `vf` every cycle. Outside `S_RUN` they hold.
- **Displayed value `dval`:**
  - `S_LOAD_A` / `S_LOAD_B`: `sw_val` (live).
  - `S_OP`: `{28'b0, SW[3:0]}`.
  - `S_RUN`: `res_q`, `port_a` or `port_b` according to `view`.
- **Digit encoding (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - c=0100111, d=0100001, E=0000110, F=0001110
  - `HEX` is combinational from `dval`.
- **LEDG:**
  - `[3:0]` one-hot state, bit order LOAD_A, LOAD_B, OP, RUN.
  - `[4]` `zf_q`, `[5]` `nf_q`, `[6]` `vf_q`.
  - `[7]` view ≠ RES.
  - `[8]` any nibble of `dval` at index ≥ `DIGITS` is nonzero (hidden digits). Always 0 when `DIGITS`=8.

## Timing

- **Reset values:**
  - Synchronisers and debounced levels: 1. Counters: 0.
  - `port_a`, `port_b`, `op`, `res_q`, flags, `LEDR`: 0.
  - State `S_LOAD_A`, `view` RES.
  - `LEDG` = 9'b000000001. `HEX` shows `sw_val`.
- **Press latency:** a press held steady is accepted `2+DEBOUNCE_CYCLES` cycles after its first sampled low. The `kp` pulse lasts 1 cycle. The register/state update occurs at the edge that ends the pulse cycle.
- **Result latency:** `res_q` is valid 1 cycle after the state becomes `S_RUN`.
- **Key hold:** holding a key produces one pulse only. Bounces shorter than `DEBOUNCE_CYCLES` produce none.
- **Reset mid-operation:** async `RST` mid-debounce or mid-sequence returns every register to its reset value immediately. No pulse is generated after release.
- **Simultaneous `kp[0]` and `kp[2]` in `S_RUN`:** enter wins; view is reset on the next entry.

## Test plan

- **Reset:** bench uses `DEBOUNCE_CYCLES`=4, `DIGITS`=8, `SW`=0. Assert `RST` → `HEX` all digits 1000000, `LEDG`=9'h001, `port_a`=`port_b`=0, `op`=0.
- **Debounce:** `KEY[0]` low 3 cycles then high → no state change. Low for 100 cycles → exactly one advance to `S_LOAD_B`, `LEDG[1:0]`=2'b10, after 6 cycles.
- **Full flow with bench ALU model `ans`=A+B:**
  - `SW`=0x00005, enter; `SW`=0x10003, enter; `SW[3:0]`=4'h2, enter.
  - Expect `port_a`=0x00000005, `port_b`=0xFFFF0003, `op`=2.
  - Expect `HEX` to show FFFF0008 one cycle into `S_RUN`, `nf_q`=1.
- **View cycling in `S_RUN`:** `KEY[2]` ×3 → display shows 00000005, then FFFF0003, then FFFF0008. `LEDG[7]` is 1, 1, 0.
- **Clear priority:** `KEY[0]` and `KEY[1]` pressed in the same cycle in `S_OP` → state `S_LOAD_A`, `port_a`=`port_b`=`op`=0.
- **Reduced digits:** `DIGITS`=4 with result 0x00010000 → `HEX` shows 0000 and `LEDG[8]`=1. Async `RST` asserted mid-press → no pulse and all outputs at their reset values.
